fact_sched: RTL and testbench

Round-robin scheduler that shares one iterative factorial engine between `NREQ` requesters. Each requester presents a 3-bit operand with a valid/ready handshake. The block grants one requester at a time and sequences the multiply-accumulate over `max(n,1)` cycles. It returns the 13-bit result on a single shared response channel, tagged with the requester index. It sits between the request sources and the factorial datapath, replacing per-requester factorial lookups with one time-shared unit.

---
 rtl/fact_pkg.sv | 23 ++
 rtl/fact_iter.sv | 49 ++++
 rtl/fact_sched.sv | 123 ++++++++++++
 tb/tb_fact_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and helpers for the time-shared factorial scheduler.
// fact_ref is the golden factorial used by elaboration checks and benches.
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int IN_W_DEF  = 3;
  localparam int OUT_W_DEF = 13;

  function automatic logic [63:0] fact_ref(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 2; i <= n; i++) begin
      r = r * 64'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/fact_iter.sv
// Iterative factorial engine: load seeds acc=1,k=n; each step multiplies acc by k
// and decrements k. done is asserted once k has reached 1 or below.
module fact_iter
  import fact_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [IN_W-1:0]  n_i,
  output logic [OUT_W-1:0] acc_o,
  output logic             done_o
);

  logic [OUT_W-1:0]      acc_q, acc_d;
  logic [IN_W-1:0]       k_q, k_d;
  logic [IN_W+OUT_W-1:0] prod;

  // Full-width product, then truncated back to the accumulator width.
  always_comb begin
    prod  = {{IN_W{1'b0}}, acc_q} * {{OUT_W{1'b0}}, k_q};
    acc_d = acc_q;
    k_d   = k_q;
    if (load_i) begin
      acc_d = OUT_W'(1);
      k_d   = n_i;
    end else if (step_i) begin
      acc_d = prod[OUT_W-1:0];
      k_d   = k_q - IN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      k_q   <= '0;
    end else begin
      acc_q <= acc_d;
      k_q   <= k_d;
    end
  end

  assign acc_o  = acc_q;
  assign done_o = (k_q <= IN_W'(1));

endmodule

// File: rtl/fact_sched.sv
// Round-robin scheduler sharing one fact_iter between NREQ requesters, with a
// single tagged response channel.
module fact_sched
  import fact_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IN_W-1:0] req_n,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [OUT_W-1:0]     rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  if (fact_ref(2**IN_W - 1) >= (64'd1 << OUT_W)) begin : g_out_w_check
    $error("fact_sched: OUT_W cannot hold (2**IN_W-1)!");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
    $error("fact_sched: NREQ must be in 2..8");
  end

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  cand, winner;
  logic             found;
  logic [IN_W-1:0]  win_n;
  logic [NREQ-1:0]  grant;
  logic             load, step, iter_done;
  logic [OUT_W-1:0] acc;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = ID_W'((int'(rr_ptr_q) + off) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    win_n = '0;
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_n    = req_n[i*IN_W +: IN_W];
        grant[i] = found;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          load     = 1'b1;
          id_d     = winner;
          rr_ptr_d = (int'(winner) == NREQ - 1) ? '0 : winner + ID_W'(1);
          state_d  = CALC;
        end
      end
      CALC: begin
        if (iter_done) state_d = DONE;
        else           step    = 1'b1;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
    end
  end

  fact_iter #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_iter (
    .clk_i (clk),
    .rst_ni(rst_n),
    .load_i(load),
    .step_i(step),
    .n_i   (win_n),
    .acc_o (acc),
    .done_o(iter_done)
  );

  // rst_n gates req_ready so nothing is accepted while reset is held.
  assign req_ready = (rst_n && state_q == IDLE) ? grant : '0;
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = acc;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fact_sched.sv
// Scoreboard bench for fact_sched: grants push expected responses, a monitor
// pops and compares on every response handshake.
module tb_fact_sched;
  localparam int NREQ  = 4;
  localparam int IN_W  = 3;
  localparam int OUT_W = 13;
  localparam int ID_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*IN_W-1:0] req_n = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [OUT_W-1:0]     rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;

  fact_sched #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_n(req_n),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int id; } exp_t;
  exp_t sb_q[$];
  int   gnt_id[$];
  int   gnt_cyc[$];
  int   fact_tab[8] = '{1, 1, 2, 6, 24, 120, 720, 5040};
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   nv;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Grant recorder: a grant seen here is accepted on the following edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          nv = int'(req_n[i*IN_W +: IN_W]);
          sb_q.push_back('{fact_tab[nv], i});
          gnt_id.push_back(i);
          gnt_cyc.push_back(cyc + 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got data %0d id %0d, expected no response",
                 rsp_data, rsp_id);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_data", int'(rsp_data), e.data);
        chk("rsp_id", int'(rsp_id), e.id);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target, input string nm);
    int t;
    t = 0;
    while (gnt_id.size() < target && t < 100) begin
      tick();
      t++;
    end
    chk(nm, gnt_id.size(), target);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || sb_q.size() != 0) && t < 100) begin
      tick();
      t++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  // Issue from an idle scheduler; optionally measure latency and response hold.
  task automatic issue(input int id, input int n, input bit lat_chk);
    int base, lat, start;
    base  = gnt_id.size();
    start = cyc;
    req_n[id*IN_W +: IN_W] = IN_W'(n);
    req_valid[id] = 1'b1;
    wait_grants(base + 1, "grant_timeout");
    req_valid[id] = 1'b0;
    if (gnt_id.size() > base) begin
      chk("grant_id", gnt_id[base], id);
      chk("accept_delay", gnt_cyc[base] - start, 1);
    end
    chk("busy_after_accept", int'(busy), 1);
    if (lat_chk) begin
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!rsp_valid && lat < 20);
      chk($sformatf("latency_n%0d", n), lat, (n < 1) ? 1 : n);
      tick();
      chk("rsp_valid_hold1", int'(rsp_valid), 0);
    end
  endtask

  initial begin
    int base, x, lat;
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, x, lat;
    // Reset state, with every requester asking
    req_valid = '1;
    repeat (3) tick();
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Round-robin with all requesters valid, n=3
    for (int i = 0; i < NREQ; i++) req_n[i*IN_W +: IN_W] = 3'd3;
    base = gnt_id.size();
    req_valid = '1;
    wait_grants(base + 5, "rr_timeout");
    req_valid = '0;
    if (gnt_id.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_order", gnt_id[base+k], k % NREQ);
        if (k > 0) chk("rr_spacing", gnt_cyc[base+k] - gnt_cyc[base+k-1], 5);
      end
    end
    wait_idle();

    // Pointer wrap: bring rr_ptr to 2, then requesters 3 and 1 together
    issue(1, 1, 1'b1);
    req_n[3*IN_W +: IN_W] = 3'd2;
    req_n[1*IN_W +: IN_W] = 3'd4;
    base = gnt_id.size();
    req_valid[3] = 1'b1;
    req_valid[1] = 1'b1;
    wait_grants(base + 1, "wrap_timeout1");
    req_valid[3] = 1'b0;
    if (gnt_id.size() > base) chk("wrap_first", gnt_id[base], 3);
    wait_grants(base + 2, "wrap_timeout2");
    req_valid[1] = 1'b0;
    if (gnt_id.size() > base + 1) chk("wrap_second", gnt_id[base+1], 1);
    wait_idle();

    // Single request: requester 2, n=5
    issue(2, 5, 1'b1);

    // Full sweep from requester 0
    for (int n = 0; n < 8; n++) issue(0, n, 1'b1);

    // Backpressure: hold DONE for 10 cycles with requester 1 pending
    rsp_ready = 1'b0;
    issue(0, 4, 1'b0);
    base = gnt_id.size();
    req_n[1*IN_W +: IN_W] = 3'd2;
    req_valid[1] = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rsp_valid && lat < 20);
    chk("bp_latency", lat, 4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_data", int'(rsp_data), 24);
      chk("bp_id", int'(rsp_id), 0);
      chk("bp_req_ready", int'(req_ready), 0);
    end
    tick();
    rsp_ready = 1'b1;
    x = cyc;
    wait_grants(base + 1, "bp_grant_timeout");
    req_valid[1] = 1'b0;
    if (gnt_id.size() > base) begin
      chk("bp_next_grant_id", gnt_id[base], 1);
      chk("bp_next_grant_edge", gnt_cyc[base] - x, 2);
    end
    wait_idle();

    // Reset two cycles into an n=6 calculation
    issue(0, 6, 1'b0);
    tick();
    tick();
    req_valid[2] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_req_ready", int'(req_ready), 0);
    chk("mid_rst_rsp_data", int'(rsp_data), 0);
    sb_q.delete();
    tick();
    tick();
    chk("mid_rst_req_ready_hold", int'(req_ready), 0);
    req_valid = '0;
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_busy", int'(busy), 0);
    issue(0, 2, 1'b1);
    wait_idle();

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
